i2c_xfc_bridge: RTL

I2C_XFC_BRIDGE -- requirements
Module: i2c_xfc_bridge

---
 rtl/i2c_xfc_bridge.sv | 133 +++++++++++++
 1 files changed

// File: rtl/i2c_xfc_bridge.sv
// I2C slave transfer bridge: strobes are queued in order and replayed onto a
// simple request/grant memory port, with read responses returned to the slave.
module i2c_xfc_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2c_xfc_write,
  input  logic        i2c_op,
  input  logic [10:0] i2c_wraddr,
  input  logic [7:0]  i2c_wdata,
  output logic [7:0]  i2c_rdata,
  output logic        i2c_xfc_read,
  output logic        mem_req,
  output logic        mem_we,
  output logic [10:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic [4:0]  fifo_level,
  output logic        ovf_err,
  output logic        rd_tout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  typedef struct packed {
    logic        op;
    logic [10:0] addr;
    logic [7:0]  data;
  } req_t;

  state_t          state;
  req_t            fifo_mem [FIFO_DEPTH];
  req_t            head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   rd_cnt;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;

  assign head  = fifo_mem[rd_ptr];
  assign full  = (fifo_level == 5'(FIFO_DEPTH));
  assign empty = (fifo_level == 5'd0);
  assign pop   = (state == ISSUE) && mem_gnt;
  // A full queue can still take a strobe when the head leaves on the same edge.
  assign push  = i2c_xfc_write && (!full || pop);

  // NOTE: queue storage carries no reset; fifo_level alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{op: i2c_op, addr: i2c_wraddr, data: i2c_wdata};
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rd_cnt       <= '0;
      fifo_level   <= 5'd0;
      ovf_err      <= 1'b0;
      rd_tout      <= 1'b0;
      i2c_rdata    <= 8'h00;
      i2c_xfc_read <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 11'h000;
      mem_wdata    <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 5'd1;
        2'b01:   fifo_level <= fifo_level - 5'd1;
        default: fifo_level <= fifo_level;
      endcase

      if (i2c_xfc_write && !push) ovf_err <= 1'b1;

      case (state)
        IDLE: begin
          if (!empty) begin
            state     <= ISSUE;
            mem_req   <= 1'b1;
            mem_we    <= !head.op;
            mem_addr  <= head.addr;
            mem_wdata <= head.data;
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state <= IDLE;
            end else begin
              state  <= WAIT_RD;
              rd_cnt <= '0;
            end
          end
        end
        WAIT_RD: begin
          if (mem_rvalid) begin
            i2c_rdata    <= mem_rdata;
            i2c_xfc_read <= 1'b1;
            state        <= RESP;
          end else if (rd_cnt == CW'(RD_TIMEOUT - 1)) begin
            i2c_rdata    <= 8'hFF;
            rd_tout      <= 1'b1;
            i2c_xfc_read <= 1'b1;
            state        <= RESP;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        RESP: begin
          i2c_xfc_read <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
